decode_hazard_pipe: RTL and testbench

Parametrised control pipeline that carries decoded instruction fields from the decode stage through DEPTH register stages toward writeback. Each stage holds a valid bit, a control/data payload, a destination register address and a write enable. The block adds three things to the fixed-depth latch chains used in decode today: per-stage flush, live source-operand hazard detection against every in-flight destination, and a forwarding-stage select. It sits between decode logic and the execute/memory/writeback stages, and its hazard output feeds the stall controller.

---
 rtl/decode_hazard_pipe.sv | 127 ++++++++++++
 tb/tb_decode_hazard_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_pipe.sv
// decode_hazard_pipe: control pipeline carrying decoded fields from decode
// toward writeback. Each stage can be flushed on its own, every in-flight
// destination is checked against the live source operands, and the youngest
// matching producer is reported as the forwarding stage.
module decode_hazard_pipe #(
  parameter  int DEPTH     = 3,
  parameter  int PAYLOAD_W = 16,
  parameter  int AW        = 5,
  parameter  int NSRC      = 2,
  localparam int SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_rd_wr,
  input  logic                 squash,
  input  logic                 stall,
  input  logic [DEPTH-1:0]     flush_mask,
  input  logic [NSRC*AW-1:0]   src_addr,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [AW-1:0]        out_rd,
  output logic                 out_rd_wr,
  output logic [NSRC-1:0]      hazard,
  output logic                 hazard_any,
  output logic [NSRC*SW-1:0]   fwd_stage,
  output logic [CW-1:0]        occupancy
);

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
    logic [AW-1:0]        rd;
    logic                 rd_wr;
  } stage_t;

  // An empty stage always carries all-zero fields, so a bubble can never
  // leak a stale rd/rd_wr into the hazard compare.
  localparam stage_t STAGE_ZERO = '0;

  stage_t r_stage [DEPTH];
  stage_t w_next  [DEPTH];
  stage_t w_in_entry;

  // Build the entry offered by decode; squashed or absent entries are zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_in_entry = STAGE_ZERO;
    if (in_valid && !squash) begin
      w_in_entry.valid   = 1'b1;
      w_in_entry.payload = in_payload;
      w_in_entry.rd      = in_rd;
      w_in_entry.rd_wr   = in_rd_wr;
    end
  end

  // Next-state: advance or hold; a flushed stage is zeroed instead of moving on.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = STAGE_ZERO;
    end
    if (stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_next[i] = flush_mask[i] ? STAGE_ZERO : r_stage[i];
      end
    end else begin
      w_next[0] = w_in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        w_next[i] = flush_mask[i-1] ? STAGE_ZERO : r_stage[i-1];
      end
    end
  end

  // Stage registers; reset clears every stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stage array is a handful of flops, not a RAM, and an empty
      // pipe must read all-zero out of reset, so every entry is reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= STAGE_ZERO;
      end
    end else begin
      // NOTE: non-blocking assignment so every stage samples the pre-edge
      // value of its neighbour; blocking here would collapse the chain.
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_next[i];
      end
    end
  end

  assign out_valid   = r_stage[DEPTH-1].valid;
  assign out_payload = r_stage[DEPTH-1].payload;
  assign out_rd      = r_stage[DEPTH-1].rd;
  assign out_rd_wr   = r_stage[DEPTH-1].rd_wr;

  // Hazard compare per source; scanning oldest to youngest lets the youngest
  // matching producer overwrite the forwarding index last.
  always_comb begin
    hazard    = '0;
    fwd_stage = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_stage[k].valid && r_stage[k].rd_wr &&
            (r_stage[k].rd == src_addr[j*AW +: AW]) &&
            (src_addr[j*AW +: AW] != '0)) begin
          hazard[j]              = 1'b1;
          fwd_stage[j*SW +: SW]  = SW'(k);
        end
      end
    end
  end

  assign hazard_any = |hazard;

  // Occupancy is the popcount of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CW'(r_stage[k].valid);
    end
  end

endmodule

// File: tb/tb_decode_hazard_pipe.sv
// Directed testbench for decode_hazard_pipe at DEPTH=3, NSRC=2, AW=5.
module tb_decode_hazard_pipe;

  localparam int DEPTH     = 3;
  localparam int PAYLOAD_W = 16;
  localparam int AW        = 5;
  localparam int NSRC      = 2;
  localparam int SW        = 2;
  localparam int CW        = 2;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [AW-1:0]        in_rd;
  logic                 in_rd_wr;
  logic                 squash;
  logic                 stall;
  logic [DEPTH-1:0]     flush_mask;
  logic [NSRC*AW-1:0]   src_addr;
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [AW-1:0]        out_rd;
  logic                 out_rd_wr;
  logic [NSRC-1:0]      hazard;
  logic                 hazard_any;
  logic [NSRC*SW-1:0]   fwd_stage;
  logic [CW-1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  decode_hazard_pipe #(
    .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .AW(AW), .NSRC(NSRC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_payload(in_payload), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .squash(squash), .stall(stall),
    .flush_mask(flush_mask), .src_addr(src_addr),
    .out_valid(out_valid), .out_payload(out_payload), .out_rd(out_rd),
    .out_rd_wr(out_rd_wr), .hazard(hazard), .hazard_any(hazard_any),
    .fwd_stage(fwd_stage), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [15:0] p, input logic [4:0] rd, input logic wr);
    in_valid   = v;
    in_payload = p;
    in_rd      = rd;
    in_rd_wr   = wr;
  endtask

  initial begin
    rst        = 1'b1;
    squash     = 1'b0;
    stall      = 1'b0;
    flush_mask = '0;
    src_addr   = '0;
    offer(1'b0, 16'h0, 5'd0, 1'b0);

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_payload", 32'(out_payload), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_hazard", 32'(hazard), 0);
    check("rst_fwd", 32'(fwd_stage), 0);
    rst = 1'b0;

    // Stream A/B/C; incoming entry is not hazard-checked in its own cycle
    offer(1'b1, 16'h0011, 5'd1, 1'b1);
    src_addr = {5'd0, 5'd1};
    #1;
    check("no_same_cycle_bypass", 32'(hazard), 0);
    tick();
    check("occ_1", 32'(occupancy), 1);
    check("haz_A_st0", 32'(hazard), 32'b01);
    check("fwd_A_st0", 32'(fwd_stage), 0);
    check("out_valid_empty", 32'(out_valid), 0);
    offer(1'b1, 16'h0022, 5'd2, 1'b1);
    tick();
    check("occ_2", 32'(occupancy), 2);
    check("fwd_A_st1", 32'(fwd_stage), 32'b0001);
    offer(1'b1, 16'h0033, 5'd0, 1'b1);
    tick();
    check("out_A_payload", 32'(out_payload), 32'h0011);
    check("out_A_rd", 32'(out_rd), 1);
    check("occ_3", 32'(occupancy), 3);
    src_addr = '0;
    #1;
    check("x0_no_hazard", 32'(hazard), 0);
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    tick();
    check("out_B_payload", 32'(out_payload), 32'h0022);
    check("occ_drain_2", 32'(occupancy), 2);
    tick();
    check("out_C_payload", 32'(out_payload), 32'h0033);
    check("out_C_rd_wr", 32'(out_rd_wr), 1);
    tick();
    check("drained_valid", 32'(out_valid), 0);
    check("drained_payload", 32'(out_payload), 0);
    check("drained_occ", 32'(occupancy), 0);

    // Stall hold with B in stage 1
    offer(1'b1, 16'h00A1, 5'd4, 1'b1);
    tick();
    offer(1'b1, 16'h00B2, 5'd6, 1'b1);
    tick();
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    tick();
    check("pre_stall_out", 32'(out_payload), 32'h00A1);
    stall = 1'b1;
    offer(1'b1, 16'h0FFF, 5'd9, 1'b1);
    tick();
    check("stall1_out", 32'(out_payload), 32'h00A1);
    check("stall1_occ", 32'(occupancy), 2);
    tick();
    check("stall2_out", 32'(out_payload), 32'h00A1);
    check("stall2_rd", 32'(out_rd), 4);
    stall = 1'b0;
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    tick();
    check("post_stall_B", 32'(out_payload), 32'h00B2);
    check("post_stall_occ", 32'(occupancy), 1);
    tick();
    check("stall_input_ignored", 32'(occupancy), 0);

    // Squash inserts a bubble
    squash = 1'b1;
    offer(1'b1, 16'h0055, 5'd3, 1'b1);
    tick();
    check("squash_occ", 32'(occupancy), 0);
    squash = 1'b0;
    offer(1'b1, 16'h0066, 5'd7, 1'b1);
    tick();
    offer(1'b1, 16'h0077, 5'd8, 1'b1);
    tick();
    check("bubble_out_valid", 32'(out_valid), 0);
    check("bubble_occ", 32'(occupancy), 2);
    offer(1'b1, 16'h0088, 5'd10, 1'b1);
    tick();
    check("out_D", 32'(out_payload), 32'h0066);
    check("occ_DEF", 32'(occupancy), 3);

    // Flush stage 1 in place while stalled
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    stall      = 1'b1;
    flush_mask = 3'b010;
    tick();
    flush_mask = 3'b000;
    check("flush_occ", 32'(occupancy), 2);
    check("flush_out_held", 32'(out_payload), 32'h0066);
    src_addr = {5'd0, 5'd8};
    #1;
    check("flushed_no_hazard", 32'(hazard), 0);
    src_addr = {5'd0, 5'd10};
    #1;
    check("haz_F_st0", 32'(hazard), 32'b01);
    check("fwd_F_st0", 32'(fwd_stage), 0);

    // Hazard priority: rd=5 in stages 0 and 2, rd=7 non-writing in stage 1
    stall = 1'b0;
    offer(1'b1, 16'h0101, 5'd5, 1'b1);
    tick();
    offer(1'b1, 16'h0202, 5'd7, 1'b0);
    tick();
    offer(1'b1, 16'h0303, 5'd5, 1'b1);
    tick();
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    stall    = 1'b1;
    src_addr = {5'd7, 5'd5};
    #1;
    check("prio_hazard", 32'(hazard), 32'b01);
    check("prio_fwd_youngest", 32'(fwd_stage), 0);
    check("prio_hazard_any", 32'(hazard_any), 1);
    flush_mask = 3'b001;
    tick();
    flush_mask = 3'b000;
    #1;
    check("prio_hazard_after", 32'(hazard), 32'b01);
    check("prio_fwd_moves_to_2", 32'(fwd_stage), 32'b0010);
    check("prio_occ", 32'(occupancy), 2);

    // Async reset mid-stream
    stall = 1'b0;
    offer(1'b1, 16'h0A0A, 5'd9, 1'b1);
    tick();
    offer(1'b1, 16'h0B0B, 5'd10, 1'b1);
    tick();
    offer(1'b1, 16'h0C0C, 5'd11, 1'b1);
    tick();
    offer(1'b0, 16'h0, 5'd0, 1'b0);
    src_addr = {5'd0, 5'd11};
    #1;
    check("pre_arst_occ", 32'(occupancy), 3);
    check("pre_arst_hazard_any", 32'(hazard_any), 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_hazard_any", 32'(hazard_any), 0);
    check("arst_occ", 32'(occupancy), 0);
    #3;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
